// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, RGB332 pixel type and colour constants.
package vga_pkg;

    typedef logic [7:0] rgb332_t;

    // 640x480 @ 60 Hz timing, 25 MHz pixel clock
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 29;

    localparam int unsigned NUM_SPR_DEF  = 4;
    localparam int unsigned COORD_W_DEF  = 10;
    localparam int unsigned GROUND_H_DEF = 40;

    localparam rgb332_t GROUND_RGB_DEF = 8'b011_001_00;
    localparam rgb332_t BG_RGB_DEF     = 8'h00;
    localparam rgb332_t BLACK          = 8'h00;

endpackage

// File: rtl/vga_sprite_engine_if.sv
// Sprite configuration inputs and video outputs of the sprite engine.
interface vga_sprite_engine_if #(
    parameter int unsigned NUM_SPR = 4,
    parameter int unsigned COORD_W = 10
) ();

    logic                         alive;
    logic [NUM_SPR*COORD_W-1:0]   spr_x;
    logic [NUM_SPR*COORD_W-1:0]   spr_y;
    logic [NUM_SPR*COORD_W-1:0]   spr_w;
    logic [NUM_SPR*COORD_W-1:0]   spr_h;
    logic [NUM_SPR*8-1:0]         spr_rgb;

    logic                         hsync;
    logic                         vsync;
    vga_pkg::rgb332_t             rgb;
    logic                         de;
    logic [COORD_W-1:0]           px;
    logic [COORD_W-1:0]           py;
    logic                         frame_start;

    // Host side: drives sprite configuration, observes video
    modport master (
        output alive, spr_x, spr_y, spr_w, spr_h, spr_rgb,
        input  hsync, vsync, rgb, de, px, py, frame_start
    );

    // Engine side
    modport slave (
        input  alive, spr_x, spr_y, spr_w, spr_h, spr_rgb,
        output hsync, vsync, rgb, de, px, py, frame_start
    );

endinterface

// File: rtl/vga_timing.sv
// Raster counters plus registered sync/de/coordinate outputs; also exposes the
// current-cycle pixel position so the parent can register rgb on the same edge.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned COORD_W  = COORD_W_DEF
) (
    input  logic               dclk,
    input  logic               clr_n,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic               frame_start,
    output logic               act_c,
    output logic               frame_end_c,
    output logic [COORD_W-1:0] x_c,
    output logic [COORD_W-1:0] y_c
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned HC_W    = $clog2(H_TOTAL + 1);
    localparam int unsigned VC_W    = $clog2(V_TOTAL + 1);

    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic            h_end_c;
    logic            v_end_c;
    logic            h_act_c;
    logic            v_act_c;

    // Decode of the current raster position
    always_comb begin
        h_end_c     = (hc == HC_W'(H_TOTAL - 1));
        v_end_c     = (vc == VC_W'(V_TOTAL - 1));
        h_act_c     = (hc >= HC_W'(H_START)) && (hc < HC_W'(H_START + H_ACTIVE));
        v_act_c     = (vc >= VC_W'(V_START)) && (vc < VC_W'(V_START + V_ACTIVE));
        act_c       = h_act_c && v_act_c;
        frame_end_c = h_end_c && v_end_c;
        x_c         = COORD_W'(hc - HC_W'(H_START));
        y_c         = COORD_W'(vc - VC_W'(V_START));
    end

    // Horizontal/vertical counters, vc steps on hc wrap
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            hc <= '0;
            vc <= '0;
        end else if (h_end_c) begin
            hc <= '0;
            vc <= v_end_c ? '0 : vc + VC_W'(1);
        end else begin
            hc <= hc + HC_W'(1);
        end
    end

    // Timing outputs registered from the current position (latency 1)
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            px          <= '0;
            py          <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= !(hc < HC_W'(H_SYNC));
            vsync       <= !(vc < VC_W'(V_SYNC));
            de          <= act_c;
            px          <= act_c ? x_c : '0;
            py          <= act_c ? y_c : '0;
            frame_start <= (hc == '0) && (vc == '0);
        end
    end

endmodule

// File: rtl/vga_sprite_engine.sv
// Rectangle sprite compositor over a VGA raster: per-frame shadowed sprite
// table, lowest-index-wins priority, ground band and background fill.
module vga_sprite_engine
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter int unsigned NUM_SPR    = NUM_SPR_DEF,
    parameter int unsigned COORD_W    = COORD_W_DEF,
    parameter int unsigned GROUND_H   = GROUND_H_DEF,
    parameter rgb332_t     GROUND_RGB = GROUND_RGB_DEF,
    parameter rgb332_t     BG_RGB     = BG_RGB_DEF
) (
    input  logic                dclk,
    input  logic                clr_n,
    vga_sprite_engine_if.slave  bus
);

    logic               act_c;
    logic               frame_end_c;
    logic [COORD_W-1:0] x_c;
    logic [COORD_W-1:0] y_c;

    logic               sh_alive;
    logic [COORD_W-1:0] sh_x   [NUM_SPR];
    logic [COORD_W-1:0] sh_y   [NUM_SPR];
    logic [COORD_W-1:0] sh_w   [NUM_SPR];
    logic [COORD_W-1:0] sh_h   [NUM_SPR];
    rgb332_t            sh_rgb [NUM_SPR];

    logic [NUM_SPR-1:0] hit_c;
    rgb332_t            pix_c;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .COORD_W  (COORD_W)
    ) u_timing (
        .dclk        (dclk),
        .clr_n       (clr_n),
        .hsync       (bus.hsync),
        .vsync       (bus.vsync),
        .de          (bus.de),
        .px          (bus.px),
        .py          (bus.py),
        .frame_start (bus.frame_start),
        .act_c       (act_c),
        .frame_end_c (frame_end_c),
        .x_c         (x_c),
        .y_c         (y_c)
    );

    // Shadow the sprite table and alive only at the last pixel of a frame
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            sh_alive <= 1'b0;
            for (int i = 0; i < NUM_SPR; i++) begin
                sh_x[i]   <= '0;
                sh_y[i]   <= '0;
                sh_w[i]   <= '0;
                sh_h[i]   <= '0;
                sh_rgb[i] <= BLACK;
            end
        end else if (frame_end_c) begin
            sh_alive <= bus.alive;
            for (int i = 0; i < NUM_SPR; i++) begin
                sh_x[i]   <= bus.spr_x[i*COORD_W +: COORD_W];
                sh_y[i]   <= bus.spr_y[i*COORD_W +: COORD_W];
                sh_w[i]   <= bus.spr_w[i*COORD_W +: COORD_W];
                sh_h[i]   <= bus.spr_h[i*COORD_W +: COORD_W];
                sh_rgb[i] <= bus.spr_rgb[i*8 +: 8];
            end
        end
    end

    // Coverage test per channel; end coordinates carry one extra bit so a
    // sprite hanging past the screen edge clips instead of wrapping.
    // A zero width or height gives an empty range, disabling the channel.
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            hit_c[i] = (x_c >= sh_x[i])
                    && ({1'b0, x_c} < ({1'b0, sh_x[i]} + {1'b0, sh_w[i]}))
                    && (y_c >= sh_y[i])
                    && ({1'b0, y_c} < ({1'b0, sh_y[i]} + {1'b0, sh_h[i]}));
        end
    end

    // Pixel priority: blanking/dead > lowest-index sprite > ground > background
    always_comb begin
        pix_c = BG_RGB;
        if (y_c >= COORD_W'(V_ACTIVE - GROUND_H)) begin
            pix_c = GROUND_RGB;
        end
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (hit_c[i]) begin
                pix_c = sh_rgb[i];
            end
        end
        if (!sh_alive || !act_c) begin
            pix_c = BLACK;
        end
    end

    // Colour output, aligned with the timing outputs
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            bus.rgb <= BLACK;
        end else begin
            bus.rgb <= pix_c;
        end
    end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine on a reduced raster (80x55) with a frame-level
// reference model of the sprite/ground/background rules.
module tb_vga_sprite_engine;
    import vga_pkg::*;

    localparam int H_A = 64, H_F = 4, H_S = 8, H_B = 4;
    localparam int V_A = 48, V_F = 2, V_S = 2, V_B = 3;
    localparam int H_T = H_A + H_F + H_S + H_B;
    localparam int V_T = V_A + V_F + V_S + V_B;
    localparam int FRAME = H_T * V_T;
    localparam int NS = 4, CW = 10, GH = 8;

    typedef struct packed {
        logic          hsync;
        logic          vsync;
        logic          de;
        logic [CW-1:0] px;
        logic [CW-1:0] py;
        logic [7:0]    rgb;
        logic          fs;
    } vid_t;

    logic dclk  = 1'b0;
    logic clr_n = 1'b0;

    vga_sprite_engine_if #(.NUM_SPR(NS), .COORD_W(CW)) bus ();

    vga_sprite_engine #(
        .H_ACTIVE (H_A), .H_FP (H_F), .H_SYNC (H_S), .H_BP (H_B),
        .V_ACTIVE (V_A), .V_FP (V_F), .V_SYNC (V_S), .V_BP (V_B),
        .NUM_SPR  (NS),  .COORD_W (CW), .GROUND_H (GH)
    ) dut (
        .dclk  (dclk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #20 dclk = ~dclk;

    int errors = 0;
    int checks = 0;

    // configuration currently driven, and the model's per-frame copy of it
    int c_x[NS], c_y[NS], c_w[NS], c_h[NS], c_rgb[NS];
    bit c_alive;
    int m_x[NS], m_y[NS], m_w[NS], m_h[NS], m_rgb[NS];
    bit m_alive;

    int   pos;
    vid_t last;
    vid_t rv;
    int   n_cyc, n_de, n_hs, n_vs;
    bit   have_fs;

    // Expected outputs for raster position p of a frame
    function automatic vid_t model(int p);
        vid_t v;
        int hc, vc, x, y;
        bit found;
        v = '0;
        hc = p % H_T;
        vc = p / H_T;
        v.hsync = (hc >= H_S);
        v.vsync = (vc >= V_S);
        v.fs    = (p == 0);
        x = hc - (H_S + H_B);
        y = vc - (V_S + V_B);
        if (x >= 0 && x < H_A && y >= 0 && y < V_A) begin
            v.de = 1'b1;
            v.px = CW'(x);
            v.py = CW'(y);
            found = 1'b0;
            if (m_alive) begin
                for (int i = 0; i < NS; i++) begin
                    if (!found && x >= m_x[i] && x < m_x[i] + m_w[i] &&
                        y >= m_y[i] && y < m_y[i] + m_h[i]) begin
                        v.rgb = 8'(m_rgb[i]);
                        found = 1'b1;
                    end
                end
                if (!found) v.rgb = (y >= V_A - GH) ? 8'h64 : 8'h00;
            end
        end
        return v;
    endfunction

    task automatic apply();
        logic [NS*CW-1:0] vx, vy, vw, vh;
        logic [NS*8-1:0]  vr;
        for (int i = 0; i < NS; i++) begin
            vx[i*CW +: CW] = CW'(c_x[i]);
            vy[i*CW +: CW] = CW'(c_y[i]);
            vw[i*CW +: CW] = CW'(c_w[i]);
            vh[i*CW +: CW] = CW'(c_h[i]);
            vr[i*8 +: 8]   = 8'(c_rgb[i]);
        end
        bus.spr_x = vx; bus.spr_y = vy; bus.spr_w = vw; bus.spr_h = vh;
        bus.spr_rgb = vr;
        bus.alive = c_alive;
    endtask

    task automatic set_spr(int i, int x, int y, int w, int h, int rgb);
        c_x[i] = x; c_y[i] = y; c_w[i] = w; c_h[i] = h; c_rgb[i] = rgb;
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < NS; i++) set_spr(i, 0, 0, 0, 0, 0);
        c_alive = 1'b0;
    endtask

    task automatic capture();
        for (int i = 0; i < NS; i++) begin
            m_x[i] = c_x[i]; m_y[i] = c_y[i]; m_w[i] = c_w[i];
            m_h[i] = c_h[i]; m_rgb[i] = c_rgb[i];
        end
        m_alive = c_alive;
    endtask

    task automatic restart_model();
        for (int i = 0; i < NS; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0; m_rgb[i] = 0;
        end
        m_alive = 1'b0;
        pos = 0;
        have_fs = 1'b0;
        n_cyc = 0; n_de = 0; n_hs = 0; n_vs = 0;
    endtask

    function automatic vid_t sample();
        vid_t o;
        o.hsync = bus.hsync; o.vsync = bus.vsync; o.de = bus.de;
        o.px = bus.px; o.py = bus.py; o.rgb = bus.rgb; o.fs = bus.frame_start;
        return o;
    endfunction

    task automatic chk_int(string tag, int got, int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic chk_vid(string tag, vid_t got, vid_t want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // One pixel clock: model the edge, then compare outputs just after it
    task automatic step();
        vid_t e, o;
        int p;
        @(posedge dclk);
        p = pos;
        e = model(p);
        if (p == FRAME - 1) capture();
        pos = (p + 1) % FRAME;
        #1;
        o = sample();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL video pos=%0d got=%h want=%h", p, o, e);
        end
        last = o;
        if (o.fs) begin
            if (have_fs) begin
                chk_int("frame_period", n_cyc, FRAME);
                chk_int("de_per_frame", n_de, H_A * V_A);
                chk_int("hsync_low_per_frame", n_hs, H_S * V_T);
                chk_int("vsync_low_per_frame", n_vs, V_S * H_T);
            end
            have_fs = 1'b1;
            n_cyc = 0; n_de = 0; n_hs = 0; n_vs = 0;
        end
        n_cyc++;
        if (o.de) n_de++;
        if (!o.hsync) n_hs++;
        if (!o.vsync) n_vs++;
    endtask

    // Advance to the next output of active pixel (x,y) and check its colour
    task automatic probe(int x, int y, logic [7:0] want, string tag);
        int target, n;
        target = ((V_S + V_B + y) * H_T + H_S + H_B + x + 1) % FRAME;
        n = 0;
        do begin
            step();
            n++;
        end while (pos != target && n <= FRAME + 1);
        checks++;
        assert (last.rgb === want) else begin
            errors++;
            $error("FAIL %s (%0d,%0d) got=%h want=%h", tag, x, y, last.rgb, want);
        end
    endtask

    initial begin
        rv = '0;
        rv.hsync = 1'b1;
        rv.vsync = 1'b1;
        clear_cfg();
        apply();
        restart_model();

        // reset state
        clr_n = 1'b0;
        repeat (3) @(negedge dclk);
        chk_vid("reset_state", sample(), rv);
        clr_n = 1'b1;
        restart_model();

        // single sprite at origin; frame 0 still shows reset shadows
        set_spr(0, 0, 0, 40, 40, 8'hE0);
        c_alive = 1'b1;
        apply();
        probe(10, 10, 8'h00, "shadow_reset");
        probe(0, 0, 8'hE0, "spr0_corner");
        probe(40, 10, 8'h00, "spr0_right_edge");
        probe(39, 39, 8'hE0, "spr0_last_px");
        probe(10, 44, 8'h64, "ground_below_spr");
        probe(50, 44, 8'h64, "ground");

        // overlapping sprites: lowest index wins, then disable sprite 0
        set_spr(0, 15, 15, 10, 10, 8'hE0);
        set_spr(1, 18, 18, 10, 10, 8'h1D);
        apply();
        probe(20, 20, 8'hE0, "priority_spr0");
        c_w[0] = 0;
        apply();
        probe(20, 20, 8'h1D, "spr0_disabled");

        // sprite clipped at the right edge, no wrap
        clear_cfg();
        c_alive = 1'b1;
        set_spr(2, H_A - 20, 5, 40, 40, 8'h1C);
        apply();
        probe(5, 8, 8'h00, "no_wrap");
        probe(50, 8, 8'h1C, "clip_inside");
        probe(63, 8, 8'h1C, "clip_last_px");
        probe(10, 44, 8'h64, "ground_no_spr");

        // mid-frame move only shows up next frame
        probe(0, 20, 8'h00, "pre_move");
        c_x[2] = 0;
        apply();
        probe(5, 25, 8'h00, "move_deferred_a");
        probe(50, 25, 8'h1C, "move_deferred_b");
        probe(5, 25, 8'h1C, "moved_a");
        probe(50, 25, 8'h00, "moved_b");

        // alive dropped mid-frame: current frame intact, next frame black
        c_alive = 1'b0;
        apply();
        probe(50, 44, 8'h64, "alive_deferred");
        probe(10, 10, 8'h00, "dead_a");
        probe(50, 44, 8'h00, "dead_b");

        // randomized sprite tables, changed at arbitrary raster positions
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NS; i++) begin
                set_spr(i, int'($urandom_range(0, 70)), int'($urandom_range(0, 55)),
                        int'($urandom_range(0, 50)), int'($urandom_range(0, 40)),
                        int'($urandom_range(0, 255)));
            end
            c_alive = ($urandom_range(0, 3) != 0);
            apply();
            repeat (int'($urandom_range(1000, 5000))) step();
        end

        // asynchronous reset in the middle of a line
        clear_cfg();
        set_spr(0, 0, 0, 40, 40, 8'hE0);
        c_alive = 1'b1;
        apply();
        while (pos % H_T != 40) step();
        clr_n = 1'b0;
        #1;
        chk_vid("reset_midline", sample(), rv);
        @(negedge dclk);
        chk_vid("reset_held", sample(), rv);
        clr_n = 1'b1;
        restart_model();
        probe(10, 10, 8'h00, "post_reset_shadow");
        probe(10, 10, 8'hE0, "post_reset_capture");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sprite_engine.md
VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

Interface
REQ-001 Parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 Parameters H_FP=16, H_SYNC=96, H_BP=48 (total 800); V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=29 (total 521); meaning porch/sync lengths in pixels/lines.
REQ-003 Parameter NUM_SPR, default 4, meaning number of rectangle sprite channels (1..8).
REQ-004 Parameter COORD_W, default 10, meaning width of all coordinate/size fields.
REQ-005 Parameters GROUND_H=40, GROUND_RGB=8'b011_001_00, BG_RGB=8'h00, meaning ground band height in lines, ground colour and background colour (RGB332).
REQ-006 dclk  in  1  pixel clock, 25 MHz, all logic on rising edge.
REQ-007 clr_n  in  1  reset, asynchronous, active-low.
REQ-008 alive  in  1  when 0, active video is forced to 8'h00.
REQ-009 spr_x, spr_y  in  NUM_SPR*COORD_W each  packed top-left coordinates, channel i at slice i.
REQ-010 spr_w, spr_h  in  NUM_SPR*COORD_W each  packed sprite sizes; w=0 or h=0 disables the channel.
REQ-011 spr_rgb  in  NUM_SPR*8  packed RGB332 colour per channel.
REQ-012 hsync, vsync  out  1 each  active-low sync.
REQ-013 rgb  out  8  {red[2:0],green[2:0],blue[1:0]}.
REQ-014 de  out  1  high during active video.
REQ-015 px, py  out  COORD_W each  active-area coordinate of the current rgb pixel (0 outside active).
REQ-016 frame_start  out  1  one-cycle pulse with the first pixel of each frame (hc=0, vc=0).

Function
REQ-017 Horizontal counter hc counts 0..H_TOTAL-1 then wraps to 0; vc increments on hc wrap and wraps 0 after V_TOTAL-1.
REQ-018 Line order: sync [0,H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), front porch; vertical identical with V_ parameters.
REQ-019 All outputs are registered; hsync, vsync, de, px, py, rgb, frame_start for a given (hc,vc) appear together exactly one dclk later (latency 1, mutually aligned).
REQ-020 Sprite inputs and alive are captured into shadow registers only on the cycle hc=H_TOTAL-1, vc=V_TOTAL-1; mid-frame input changes take effect next frame (no tearing).
REQ-021 Channel i covers pixel (x,y) iff spr_x<=x<spr_x+spr_w and spr_y<=y<spr_y+spr_h, sums computed at COORD_W+1 bits (no wrap; sprites may extend past screen edge and are clipped).
REQ-022 Priority when de: alive=0 -> 8'h00; else lowest-index covering sprite; else ground band (y>=V_ACTIVE-GROUND_H) -> GROUND_RGB; else BG_RGB.
REQ-023 Outside active video rgb=8'h00, de=0, px=py=0.
REQ-024 Sprites overlap the ground band and each other freely; no sprite state beyond the shadow registers.

Reset
REQ-025 On clr_n=0: hc=vc=0, shadow registers 0 (all sprites disabled, alive=0), rgb=0, de=0, px=py=0, frame_start=0, hsync=vsync=1.
REQ-026 Reset mid-frame aborts immediately; after release the first frame_start occurs one cycle after the first counted edge, and shadows stay 0 until the first capture point.

Structure
REQ-027 Shared package vga_pkg holds timing defaults, the RGB332 type and colour constants.
REQ-028 One sub-module vga_timing (counters, syncs, de, px/py); sprite compare/priority mux lives in vga_sprite_engine.

Verification
REQ-029 Reset release, defaults -> hsync low 96 clocks per 800-clock line, vsync low 2 lines per 521, de high 640x480 per frame, frame_start every 416800 clocks.
REQ-030 Sprite0 x=0,y=0,w=40,h=40,rgb=E0, alive=1 -> rgb=E0 at px 0..39, py 0..39; px=40 gives BG_RGB.
REQ-031 Sprite0 and sprite1 both cover (100,100), colours E0/1D -> rgb=E0; sprite0 w=0 -> 1D.
REQ-032 Sprite x=620,w=40 -> pixels 620..639 coloured, no wrap at px 0..19; py 460 with no sprite -> GROUND_RGB.
REQ-033 Change spr_x at py=200 -> output unchanged until next frame_start, then moved.
REQ-034 alive deasserted mid-frame -> current frame unchanged, next frame all rgb=0; clr_n pulsed mid-line -> outputs at reset values within the same cycle.
